// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the external memory port arbiter.
// Holds the sequencer states, requester indices and the fixed-priority select.
package mem_arb_pkg;

  localparam int unsigned NUM_REQ   = 3;
  localparam int unsigned REQ_FETCH = 0;
  localparam int unsigned REQ_LOAD  = 1;
  localparam int unsigned REQ_STORE = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } arbStateT;

  // One-hot pick of the highest-priority request (store > load > fetch).
  function automatic logic [NUM_REQ-1:0] prioSel(input logic [NUM_REQ-1:0] r);
    logic [NUM_REQ-1:0] sel;
    sel = '0;
    if (r[REQ_STORE])      sel[REQ_STORE] = 1'b1;
    else if (r[REQ_LOAD])  sel[REQ_LOAD]  = 1'b1;
    else if (r[REQ_FETCH]) sel[REQ_FETCH] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Fixed-priority owner of the single memory port (enable/rw/mfc).
// Grants one FSM at a time, pulses done on completion and err on mfc timeout.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CW      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] reqRw,
  input  logic               mfc,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] done,
  output logic               err,
  output logic               enable,
  output logic               rw,
  output logic               busy
);

  arbStateT           state, stateNext;
  logic [CW-1:0]      cnt, cntNext;
  logic [NUM_REQ-1:0] grantNext, doneNext, sel;
  logic               errNext, enableNext, rwNext, busyNext;
  logic               ownerReq;

  assign ownerReq = |(req & grant);

  // Every output is the registered copy of its next-value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      grant  <= '0;
      done   <= '0;
      err    <= 1'b0;
      enable <= 1'b0;
      rw     <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= stateNext;
      cnt    <= cntNext;
      grant  <= grantNext;
      done   <= doneNext;
      err    <= errNext;
      enable <= enableNext;
      rw     <= rwNext;
      busy   <= busyNext;
    end
  end

  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    grantNext  = grant;
    doneNext   = '0;
    errNext    = 1'b0;
    enableNext = 1'b0;
    rwNext     = rw;
    sel        = '0;

    case (state)
      IDLE: begin
        if (|req) begin
          sel        = prioSel(req);
          grantNext  = sel;
          rwNext     = |(reqRw & sel);
          enableNext = 1'b1;
          cntNext    = '0;
          stateNext  = ACCESS;
        end
      end

      ACCESS: begin
        if (cnt != CW'(TIMEOUT)) cntNext = cnt + CW'(1);
        // mfc wins over timeout, timeout wins over requester abort.
        if (mfc) begin
          doneNext  = grant;
          stateNext = RELEASE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          doneNext  = grant;
          errNext   = 1'b1;
          stateNext = RELEASE;
        end else if (!ownerReq) begin
          grantNext = '0;
          stateNext = IDLE;
        end else begin
          enableNext = 1'b1;
        end
      end

      RELEASE: begin
        if (!ownerReq) begin
          grantNext = '0;
          stateNext = IDLE;
        end
      end

      default: begin
        grantNext = '0;
        stateNext = IDLE;
      end
    endcase

    busyNext = (stateNext != IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with hand-computed expected outputs.
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req, reqRw;
  logic       mfc;
  logic [2:0] grant, done;
  logic       err, enable, rw, busy;

  int vecCount  = 0;
  int missCount = 0;

  mem_port_arbiter #(.TIMEOUT(15), .CW(4)) dut (
    .clk(clk), .rst(rst), .req(req), .reqRw(reqRw), .mfc(mfc),
    .grant(grant), .done(done), .err(err), .enable(enable), .rw(rw), .busy(busy)
  );

  always #5 clk = ~clk;

  // Packed view: {grant, done, err, enable, rw, busy}.
  function automatic logic [9:0] pk(input logic [2:0] g, input logic [2:0] d,
                                    input logic e, input logic en,
                                    input logic w, input logic b);
    return {g, d, e, en, w, b};
  endfunction

  task automatic checkVec(input string tag, input logic [9:0] got, input logic [9:0] want);
    vecCount++;
    if (got !== want) begin
      missCount++;
      $display("FAIL %s: got g=%b d=%b e=%b en=%b rw=%b busy=%b, want g=%b d=%b e=%b en=%b rw=%b busy=%b",
               tag, got[9:7], got[6:4], got[3], got[2], got[1], got[0],
               want[9:7], want[6:4], want[3], want[2], want[1], want[0]);
    end
  endtask

  function automatic logic [9:0] obs();
    return pk(grant, done, err, enable, rw, busy);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req = '0; reqRw = '0; mfc = 1'b0;
    tick(); tick();
    checkVec("reset", obs(), pk(3'b000, 3'b000, 0, 0, 0, 0));
    rst = 1'b0;
    tick();
    checkVec("idle_after_reset", obs(), pk(3'b000, 3'b000, 0, 0, 0, 0));

    // Single read, mfc on 3rd ACCESS cycle.
    req = 3'b001; reqRw = 3'b000;
    tick(); checkVec("rd_grant", obs(), pk(3'b001, 3'b000, 0, 1, 0, 1));
    tick(); checkVec("rd_acc2", obs(), pk(3'b001, 3'b000, 0, 1, 0, 1));
    tick(); checkVec("rd_acc3", obs(), pk(3'b001, 3'b000, 0, 1, 0, 1));
    mfc = 1'b1;
    tick(); checkVec("rd_done", obs(), pk(3'b001, 3'b001, 0, 0, 0, 1));
    mfc = 1'b0;
    tick(); checkVec("rd_release", obs(), pk(3'b001, 3'b000, 0, 0, 0, 1));
    req = 3'b000;
    tick(); checkVec("rd_idle", obs(), pk(3'b000, 3'b000, 0, 0, 0, 0));

    // Contention: store, then load, then fetch.
    req = 3'b111; reqRw = 3'b100;
    tick(); checkVec("ct_store_grant", obs(), pk(3'b100, 3'b000, 0, 1, 1, 1));
    mfc = 1'b1;
    tick(); checkVec("ct_store_done", obs(), pk(3'b100, 3'b100, 0, 0, 1, 1));
    mfc = 1'b0; req = 3'b011;
    tick(); checkVec("ct_store_rel", obs(), pk(3'b000, 3'b000, 0, 0, 1, 0));
    tick(); checkVec("ct_load_grant", obs(), pk(3'b010, 3'b000, 0, 1, 0, 1));
    mfc = 1'b1;
    tick(); checkVec("ct_load_done", obs(), pk(3'b010, 3'b010, 0, 0, 0, 1));
    mfc = 1'b0; req = 3'b001;
    tick(); checkVec("ct_load_rel", obs(), pk(3'b000, 3'b000, 0, 0, 0, 0));
    tick(); checkVec("ct_fetch_grant", obs(), pk(3'b001, 3'b000, 0, 1, 0, 1));
    mfc = 1'b1;
    tick(); checkVec("ct_fetch_done", obs(), pk(3'b001, 3'b001, 0, 0, 0, 1));
    mfc = 1'b0; req = 3'b000;
    tick(); checkVec("ct_idle", obs(), pk(3'b000, 3'b000, 0, 0, 0, 0));

    // Timeout: err/done exactly 15 cycles after enable rose.
    req = 3'b010; reqRw = 3'b000;
    tick(); checkVec("to_grant", obs(), pk(3'b010, 3'b000, 0, 1, 0, 1));
    for (int i = 1; i < 15; i++) begin
      tick(); checkVec($sformatf("to_wait%0d", i), obs(), pk(3'b010, 3'b000, 0, 1, 0, 1));
    end
    tick(); checkVec("to_err", obs(), pk(3'b010, 3'b010, 1, 0, 0, 1));
    tick(); checkVec("to_hold1", obs(), pk(3'b010, 3'b000, 0, 0, 0, 1));
    tick(); checkVec("to_hold2", obs(), pk(3'b010, 3'b000, 0, 0, 0, 1));
    req = 3'b000;
    tick(); checkVec("to_idle", obs(), pk(3'b000, 3'b000, 0, 0, 0, 0));

    // Requester abort on 2nd ACCESS cycle, stray mfc ignored.
    req = 3'b001;
    tick(); checkVec("ab_grant", obs(), pk(3'b001, 3'b000, 0, 1, 0, 1));
    tick(); checkVec("ab_acc2", obs(), pk(3'b001, 3'b000, 0, 1, 0, 1));
    req = 3'b000;
    tick(); checkVec("ab_abort", obs(), pk(3'b000, 3'b000, 0, 0, 0, 0));
    mfc = 1'b1;
    tick(); checkVec("ab_stray_mfc", obs(), pk(3'b000, 3'b000, 0, 0, 0, 0));
    mfc = 1'b0;

    // Reset during ACCESS with mfc high clears outputs asynchronously.
    req = 3'b001;
    tick(); checkVec("rs_grant", obs(), pk(3'b001, 3'b000, 0, 1, 0, 1));
    tick();
    mfc = 1'b1;
    #2 rst = 1'b1;
    #1 checkVec("rs_async_clear", obs(), pk(3'b000, 3'b000, 0, 0, 0, 0));
    tick(); checkVec("rs_held", obs(), pk(3'b000, 3'b000, 0, 0, 0, 0));
    rst = 1'b0; mfc = 1'b0;
    tick(); checkVec("rs_regrant", obs(), pk(3'b001, 3'b000, 0, 1, 0, 1));
    mfc = 1'b1;
    tick(); checkVec("rs_done", obs(), pk(3'b001, 3'b001, 0, 0, 0, 1));
    mfc = 1'b0; req = 3'b000;
    tick(); checkVec("rs_idle", obs(), pk(3'b000, 3'b000, 0, 0, 0, 0));

    // RELEASE hold while store is pending; reqRw change after grant ignored.
    req = 3'b001; reqRw = 3'b100;
    tick(); checkVec("rh_grant", obs(), pk(3'b001, 3'b000, 0, 1, 0, 1));
    mfc = 1'b1;
    tick(); checkVec("rh_done", obs(), pk(3'b001, 3'b001, 0, 0, 0, 1));
    mfc = 1'b0; req = 3'b101;
    for (int i = 0; i < 4; i++) begin
      tick(); checkVec($sformatf("rh_hold%0d", i), obs(), pk(3'b001, 3'b000, 0, 0, 0, 1));
    end
    req = 3'b100;
    tick(); checkVec("rh_release", obs(), pk(3'b000, 3'b000, 0, 0, 0, 0));
    tick(); checkVec("rh_store_grant", obs(), pk(3'b100, 3'b000, 0, 1, 1, 1));
    reqRw = 3'b000;
    tick(); checkVec("rh_rw_held", obs(), pk(3'b100, 3'b000, 0, 1, 1, 1));
    mfc = 1'b1;
    tick(); checkVec("rh_store_done", obs(), pk(3'b100, 3'b100, 0, 0, 1, 1));
    mfc = 1'b0; req = 3'b000;
    tick(); checkVec("rh_idle", obs(), pk(3'b000, 3'b000, 0, 0, 1, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
